// File: rtl/toggle_debounce_pkg.sv
// Shared types for the push-button debouncer: FSM state encodings and a
// small decode helper used by the top level.
package toggle_debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'b00,
        S_RISE_CHK = 2'b01,
        S_HIGH     = 2'b10,
        S_FALL_CHK = 2'b11
    } state_t;

    function automatic logic is_qualifying(input state_t s);
        return (s == S_RISE_CHK) || (s == S_FALL_CHK);
    endfunction

endpackage

// File: rtl/toggle_debounce_sync_ff.sv
// Parameterised flop-chain synchroniser with synchronous active-low reset;
// shared by every button input of the lab top level.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_debounce.sv
// Debounces a raw push-button and emits one out_T pulse per accepted press
// for the downstream T flip-flop; also provides the debounced level.
//
// state      | meaning
// S_LOW      | button stable low
// S_RISE_CHK | qualifying a rise, cnt = consecutive high samples so far
// S_HIGH     | button stable high
// S_FALL_CHK | qualifying a fall, cnt = consecutive low samples so far
module toggle_debounce
    import toggle_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_btn,
    output logic out_T,
    output logic out_level,
    output logic out_busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             t_nxt;
    logic             level_nxt;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_btn),
        .q     (btn_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_LOW;
            cnt       <= '0;
            out_T     <= 1'b0;
            out_level <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_T     <= t_nxt;
            out_level <= level_nxt;
        end
    end

    // The counter is cleared on every exit from a check state, so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        t_nxt     = 1'b0;
        level_nxt = out_level;
        case (state)
            S_LOW: begin
                if (btn_s) begin
                    state_nxt = S_RISE_CHK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_RISE_CHK: begin
                if (!btn_s) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    t_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!btn_s) begin
                    state_nxt = S_FALL_CHK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_FALL_CHK: begin
                if (btn_s) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        out_busy = is_qualifying(state);
    end

endmodule

// File: tb/tb_toggle_debounce.sv
// Self-checking bench for toggle_debounce: vector table, hand-written corner
// sequences, a TFF integration run and randomized bouncing input vs a model.
module tb_toggle_debounce;

    localparam int DC = 4;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset;
    logic in_btn;
    logic out_T;
    logic out_level;
    logic out_busy;

    int tests = 0;
    int fails = 0;

    toggle_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_btn    (in_btn),
        .out_T     (out_T),
        .out_level (out_level),
        .out_busy  (out_busy)
    );

    always #10 clk = ~clk;

    // Downstream T flip-flop with its active-high reset driven by ~reset.
    logic tff_q;
    int   tff_toggles = 0;
    always @(posedge clk) begin
        if (!reset) begin
            tff_q <= 1'b0;
        end else if (out_T) begin
            tff_q       <= ~tff_q;
            tff_toggles <= tff_toggles + 1;
        end
    end

    // Reference model: a delay line for the synchroniser plus a run-length
    // count of samples that disagree with the accepted level.
    logic [SS-1:0] m_hist = '0;
    int            m_run  = 0;
    logic          m_level = 1'b0;
    logic          m_T     = 1'b0;

    task automatic model_step(input logic b, input logic r);
        logic s;
        if (!r) begin
            m_hist  = '0;
            m_run   = 0;
            m_level = 1'b0;
            m_T     = 1'b0;
        end else begin
            s      = m_hist[SS-1];
            m_hist = {m_hist[SS-2:0], b};
            m_T    = 1'b0;
            if (s != m_level) begin
                m_run++;
                if (m_run == DC) begin
                    m_level = s;
                    m_T     = s;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    int edge_no    = 0;
    int pulses     = 0;
    int last_pulse = -1;

    task automatic tick(input logic b, input logic r);
        in_btn = b;
        reset  = r;
        @(posedge clk);
        model_step(b, r);
        @(negedge clk);
        edge_no++;
        if (out_T === 1'b1) begin
            pulses++;
            last_pulse = edge_no;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check_bit({tag, "_T"},     out_T,     m_T);
        check_bit({tag, "_level"}, out_level, m_level);
        check_bit({tag, "_busy"},  out_busy,  logic'(m_run != 0));
    endtask

    task automatic start_window();
        edge_no    = 0;
        pulses     = 0;
        last_pulse = -1;
    endtask

    typedef struct {
        logic btn;
        logic rst;
        logic e_T;
        logic e_level;
        logic e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic b, input logic r,
                                input logic t, input logic l, input logic y);
        vec_t v;
        v.btn = b; v.rst = r; v.e_T = t; v.e_level = l; v.e_busy = y;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_btn = 1'b0;
        reset  = 1'b0;

        // Reset, clean press held 12 cycles, then release held 7 cycles.
        add(0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 1);
        add(1, 1, 0, 0, 1);
        add(1, 1, 0, 0, 1);
        add(1, 1, 1, 1, 0);
        for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].btn, vecs[i].rst);
            check_bit($sformatf("vec%0d_T", i),     out_T,     vecs[i].e_T);
            check_bit($sformatf("vec%0d_level", i), out_level, vecs[i].e_level);
            check_bit($sformatf("vec%0d_busy", i),  out_busy,  vecs[i].e_busy);
        end

        // Bounce: 1,1,0,1 then held; accepted after four uninterrupted samples.
        tick(0, 0);
        tick(0, 0);
        start_window();
        tick(1, 1);
        tick(1, 1);
        tick(0, 1);
        for (int i = 0; i < 11; i++) tick(1, 1);
        check("bounce_pulses", pulses, 1);
        check("bounce_edge", last_pulse, 9);
        check_bit("bounce_level", out_level, 1'b1);

        // Reset in the middle of a rise qualification, button still held.
        tick(0, 0);
        tick(0, 0);
        start_window();
        for (int i = 0; i < 4; i++) tick(1, 1);
        check_bit("midrst_busy_before", out_busy, 1'b1);
        tick(1, 0);
        tick(1, 0);
        check_bit("midrst_T", out_T, 1'b0);
        check_bit("midrst_level", out_level, 1'b0);
        check_bit("midrst_busy", out_busy, 1'b0);
        check("midrst_no_pulse", pulses, 0);
        start_window();
        for (int i = 0; i < 10; i++) tick(1, 1);
        check("midrst_after_pulses", pulses, 1);
        check("midrst_after_edge", last_pulse, 6);

        // Reset asserted on the very edge that would accept the press.
        tick(0, 0);
        tick(0, 0);
        start_window();
        for (int i = 0; i < 5; i++) tick(1, 1);
        tick(1, 0);
        check_bit("rst_accept_T", out_T, 1'b0);
        check_bit("rst_accept_level", out_level, 1'b0);
        check("rst_accept_pulses", pulses, 0);

        // Integration with the TFF: three clean presses.
        tick(0, 0);
        tick(0, 0);
        begin
            int base;
            base = tff_toggles;
            start_window();
            for (int p = 0; p < 3; p++) begin
                for (int i = 0; i < 10; i++) tick(1, 1);
                for (int i = 0; i < 10; i++) tick(0, 1);
            end
            check("tff_pulses", pulses, 3);
            check("tff_toggles", tff_toggles - base, 3);
            check_bit("tff_q_final", tff_q, 1'b1);
        end

        // Randomized bouncing bursts with occasional resets.
        tick(0, 0);
        check_model("rnd_init");
        for (int b = 0; b < 80; b++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                    tick(logic'($urandom_range(0, 1)), 1'b0);
                    check_model("rnd_rst");
                end
            end else begin
                logic cur;
                int   len;
                cur = logic'($urandom_range(0, 1));
                len = $urandom_range(1, 12);
                for (int i = 0; i < len; i++) begin
                    logic v;
                    v = cur;
                    if ($urandom_range(0, 5) == 0) v = ~cur;
                    tick(v, 1'b1);
                    check_model("rnd");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
